// File: rtl/regfile_sb.sv
// regfile_sb: decode-stage register file with XZR, write-to-read bypass,
// sequenced hardware clear after reset and a per-register busy scoreboard.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   ready                 clear sequence finished, ports live
//   rd_en                 capture a read on both ports this cycle
//   rd_addr1/2            read indices
//   rd_data1/2            registered read data (1-cycle latency)
//   rd_busy1/2            registered scoreboard bit for each read index
//   wr_en/wr_addr/wr_data writeback port; clears the busy bit of wr_addr
//   rsv_en/rsv_addr       reserve a destination (sets its busy bit)
//   busy_count            registered popcount of the busy vector
module regfile_sb #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned ADDR_BITS = 5,
    parameter bit          ZERO_REG  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr1,
    input  logic [ADDR_BITS-1:0] rd_addr2,
    output logic [WIDTH-1:0]     rd_data1,
    output logic [WIDTH-1:0]     rd_data2,
    output logic                 rd_busy1,
    output logic                 rd_busy2,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rsv_en,
    input  logic [ADDR_BITS-1:0] rsv_addr,
    output logic [ADDR_BITS:0]   busy_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    // DEPTH-1 is the all-ones index.
    localparam logic [ADDR_BITS-1:0] XZR_IDX = '1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                 state, state_nx;
    logic [ADDR_BITS-1:0]   clr_cnt;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]       busy, busy_nx;
    logic [ADDR_BITS:0]     busy_cnt_nx;
    logic [WIDTH-1:0]       rd_val1, rd_val2;
    logic                   bsy_val1, bsy_val2;
    logic                   wr_xzr, rsv_xzr;
    logic                   hit1, hit2;

    function automatic logic is_xzr(input logic [ADDR_BITS-1:0] a);
        return ZERO_REG && (a == XZR_IDX);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_nx;
    end

    // Next state: leave CLEAR after the edge that zeroes the last entry
    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (clr_cnt == XZR_IDX) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = CLEAR;
        endcase
    end

    assign ready = (state == RUN);

    always_comb begin
        wr_xzr  = is_xzr(wr_addr);
        rsv_xzr = is_xzr(rsv_addr);
        hit1    = wr_en && (wr_addr == rd_addr1);
        hit2    = wr_en && (wr_addr == rd_addr2);

        rd_val1 = is_xzr(rd_addr1) ? '0 : (hit1 ? wr_data : mem[rd_addr1]);
        rd_val2 = is_xzr(rd_addr2) ? '0 : (hit2 ? wr_data : mem[rd_addr2]);
        // A same-cycle reservation is deliberately not forwarded.
        bsy_val1 = busy[rd_addr1] & ~hit1;
        bsy_val2 = busy[rd_addr2] & ~hit2;

        // Retire first, then reserve: a same-index reserve wins.
        busy_nx = busy;
        if (wr_en && !wr_xzr)   busy_nx[wr_addr]  = 1'b0;
        if (rsv_en && !rsv_xzr) busy_nx[rsv_addr] = 1'b1;

        busy_cnt_nx = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            busy_cnt_nx = busy_cnt_nx + (ADDR_BITS+1)'(busy_nx[i]);
    end

    // Storage array: zeroed by the clear sequence, no reset of its own
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[clr_cnt] <= '0;
            else if (wr_en && !wr_xzr)
                mem[wr_addr] <= wr_data;
        end
    end

    // Clear counter, scoreboard and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt    <= '0;
            busy       <= '0;
            busy_count <= '0;
            rd_data1   <= '0;
            rd_data2   <= '0;
            rd_busy1   <= 1'b0;
            rd_busy2   <= 1'b0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            busy       <= busy_nx;
            busy_count <= busy_cnt_nx;
            if (rd_en) begin
                rd_data1 <= rd_val1;
                rd_data2 <= rd_val2;
                rd_busy1 <= bsy_val1;
                rd_busy2 <= bsy_val2;
            end
        end
    end

endmodule
